mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: mthi/mtlo, mult/multu/madd/maddu/msub, div/divu.
// Optional build macro MULDIV_FAST_MUL_EN: multiply-class ops commit at the start edge with no busy cycles.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo commit immediately
// S_RUN  | result held in pend_*, counting down cnt until commit
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  ctrl,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        outSel,
  output logic [31:0] out,
  output logic        busy
);

  localparam logic [3:0] MT_DISABLED = 4'd0;
  localparam logic [3:0] MT_MULT     = 4'd1;
  localparam logic [3:0] MT_MULTU    = 4'd2;
  localparam logic [3:0] MT_DIV      = 4'd3;
  localparam logic [3:0] MT_DIVU     = 4'd4;
  localparam logic [3:0] MT_MADD     = 4'd5;
  localparam logic [3:0] MT_MADDU    = 4'd6;
  localparam logic [3:0] MT_MSUB     = 4'd7;
  localparam logic [3:0] MT_SETHI    = 4'd8;
  localparam logic [3:0] MT_SETLO    = 4'd9;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  logic [63:0]        acc;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic [31:0]        div_b;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  logic        is_mul, is_div, res_wr;
  logic [31:0] res_hi, res_lo;

  assign acc    = {hi, lo};
  assign prod_s = $signed(opA) * $signed(opB);
  assign prod_u = {32'd0, opA} * {32'd0, opB};

  // Substitute a harmless divisor for /0 and INT_MIN/-1; both cases are overridden below.
  assign div_ovf = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
  assign div_b   = ((opB == 32'd0) || div_ovf) ? 32'd1 : opB;
  assign quo_s   = $signed(opA) / $signed(div_b);
  assign rem_s   = $signed(opA) % $signed(div_b);
  assign quo_u   = opA / div_b;
  assign rem_u   = opA % div_b;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    res_wr = 1'b1;
    res_hi = hi;
    res_lo = lo;
    case (ctrl)
      MT_MULT: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      MT_MULTU: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      MT_MADD: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = acc + prod_s;
      end
      MT_MADDU: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = acc + prod_u;
      end
      MT_MSUB: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = acc - prod_s;
      end
      MT_DIV: begin
        is_div = 1'b1;
        if (opB == 32'd0) begin
          res_wr = 1'b0;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MT_DIVU: begin
        is_div = 1'b1;
        if (opB == 32'd0) begin
          res_wr = 1'b0;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ctrl == MT_SETHI) begin
              hi <= opA;
            end else if (ctrl == MT_SETLO) begin
              lo <= opA;
            end else if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
              hi <= res_hi;
              lo <= res_lo;
`else
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= res_wr;
              cnt     <= CNT_W'(MUL_CYCLES);
              state   <= S_RUN;
`endif
            end else if (is_div) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= res_wr;
              cnt     <= CNT_W'(DIV_CYCLES);
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cnt == CNT_W'(1)) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign out  = outSel ? hi : lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit; expected HI/LO pairs queued at issue, popped at completion.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_mul_div_unit;

  localparam logic [3:0] MT_DISABLED = 4'd0;
  localparam logic [3:0] MT_MULT     = 4'd1;
  localparam logic [3:0] MT_MULTU    = 4'd2;
  localparam logic [3:0] MT_DIV      = 4'd3;
  localparam logic [3:0] MT_DIVU     = 4'd4;
  localparam logic [3:0] MT_MADD     = 4'd5;
  localparam logic [3:0] MT_MADDU    = 4'd6;
  localparam logic [3:0] MT_MSUB     = 4'd7;
  localparam logic [3:0] MT_SETHI    = 4'd8;
  localparam logic [3:0] MT_SETLO    = 4'd9;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 5;
`endif
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        outSel = 1'b0;
  logic [31:0] out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ctrl(ctrl),
    .opA(opA), .opB(opB), .outSel(outSel), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  // The hazard unit must never let a request through while busy.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(start && busy)) else begin
        n_err++;
        $error("FAIL start_while_busy observed=1 expected=0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      outSel = 1'b1;
      #1;
      check({tag, "_hi"}, out, e[63:32]);
      outSel = 1'b0;
      #1;
      check({tag, "_lo"}, out, e[31:0]);
    end
  endtask

  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    int cyc;
    exp_q.push_back({ehi, elo});
    ctrl  = c;
    opA   = a;
    opB   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    ctrl  = MT_DISABLED;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(ecyc));
    check_hilo(tag);
  endtask

  initial begin
    #3;
    outSel = 1'b1;
    #1;
    check("reset_hi", out, 32'd0);
    outSel = 1'b0;
    #1;
    check("reset_lo", out, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    op("mthi", MT_SETHI, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0000, 0);
    op("mtlo", MT_SETLO, 32'hCAFE_BABE, 32'd0, 32'h1234_5678, 32'hCAFE_BABE, 0);

    op("mult",  MT_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
    op("multu", MT_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT);
    op("mult67", MT_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

    op("div_m7_2", MT_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    op("divu_by0", MT_DIVU, 32'd7,         32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    op("div_by0",  MT_DIV,  32'd9,         32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);

    op("mthi0", MT_SETHI, 32'd0,         32'd0, 32'd0, 32'hFFFF_FFFD, 0);
    op("mtlo1", MT_SETLO, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
    op("madd",  MT_MADD,  32'd1, 32'd1, 32'd1, 32'd0, MUL_LAT);
    op("msub",  MT_MSUB,  32'd2, 32'd1, 32'd0, 32'hFFFF_FFFE, MUL_LAT);
    op("maddu", MT_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, MUL_LAT);

    op("div_ovf",   MT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
    op("div_7_m2",  MT_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
    op("divu_big",  MT_DIVU, 32'hFFFF_FFFF, 32'd2,         32'd1, 32'h7FFF_FFFF, DIV_LAT);
    op("unknown",   4'hF,    32'hDEAD_BEEF, 32'd5,         32'd1, 32'h7FFF_FFFF, 0);
    op("disabled",  MT_DISABLED, 32'hDEAD_BEEF, 32'd5,     32'd1, 32'h7FFF_FFFF, 0);

    // Reset asserted in the third busy cycle of a divide.
    ctrl  = MT_DIV;
    opA   = 32'd100;
    opB   = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    ctrl  = MT_DISABLED;
    check("rst_busy_c1", {31'd0, busy}, 32'd1);
    tick();
    tick();
    check("rst_busy_c3", {31'd0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    outSel = 1'b1;
    #1;
    check("rst_mid_hi", out, 32'd0);
    outSel = 1'b0;
    #1;
    check("rst_mid_lo", out, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_post_busy", {31'd0, busy}, 32'd0);
    op("mtlo_after_rst", MT_SETLO, 32'h0000_0055, 32'd0, 32'd0, 32'h0000_0055, 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
